// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// state encoding, default operand width and counter sizing helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: $clog2(width), never less than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle for serial_add_ctrl. The requester drives the
// operation request; the controller returns status and the result.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b, abort,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b, abort,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// FullAdder_gate: single-bit full adder built from gate primitives.
// This is the only arithmetic element in the serial datapath.
module FullAdder_gate (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x1 (ab_x, a, b);
    xor g_x2 (sum, ab_x, cin);
    and g_a1 (ab_a, a, b);
    and g_a2 (cx_a, ab_x, cin);
    or  g_o1 (cout, ab_a, cx_a);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor controller. Operands are
// shifted LSB first through one FullAdder_gate cell and a carry flop;
// the result is published to the output registers only when complete.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam int SH_W  = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [SH_W-1:0]  shreg;      // partial result, bits 0..WIDTH-2
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             cell_sum;
    logic             cell_cout;

    FullAdder_gate u_cell (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // Sequencer and datapath: accept, shift one bit per RUN cycle, publish on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            shreg  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1, so invert B and force carry-in.
                        opa    <= bus.a;
                        opb    <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub | bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        shreg <= SH_W'({cell_sum, shreg} >> 1);
                        opa   <= opa >> 1;
                        opb   <= opb >> 1;
                        carry <= cell_cout;
                        if (cnt == LAST_BIT) begin
                            // carry still holds the carry into the MSB here.
                            sum_q  <= {cell_sum, shreg};
                            cout_q <= cell_cout;
                            ovf_q  <= carry ^ cell_cout;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed and random operations, expected
// results queued at issue time and consumed by an independent monitor.
module tb_serial_add_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int          tests;
    int          fails;
    exp_t        q[$];

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input int unsigned c);
        exp_t        r;
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        int          sa;
        int          sb;
        int          s;
        ua = a;
        ub = b;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full   = ua - ub;
            r.cout = (ua >= ub);
            s      = sa - sb;
        end else begin
            full   = ua + ub + cin;
            r.cout = ((full >> W) & 1) != 0;
            s      = sa + sb + int'(cin);
        end
        r.sum = W'(full);
        r.ovf = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        r.cyc = c;
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(bus.sum), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sum", 32'(bus.sum), 32'(e.sum));
                check("cout", 32'(bus.cout), 32'(e.cout));
                check("ovf", 32'(bus.ovf), 32'(e.ovf));
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following the sampling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input bit expect_done);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
        if (expect_done) q.push_back(model(a, b, cin, sub, cyc + 1 + W));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        issue(a, b, cin, sub, 1'b1);
        idle(W + 1);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.abort = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Directed arithmetic cases
        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h05, 8'h07, 1'b0, 1'b1);
        do_op(8'h07, 8'h05, 1'b0, 1'b1);
        do_op(8'h07, 8'h05, 1'b1, 1'b1);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);

        // start during RUN bit 3 and during DONE is ignored; next IDLE start accepted
        issue(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        idle(3);
        issue(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
        idle(4);
        check("busy_in_run", 32'(bus.busy), 32'd1);
        issue(8'hC3, 8'h3C, 1'b0, 1'b1, 1'b0);
        do_op(8'h21, 8'h43, 1'b1, 1'b0);

        // Abort at RUN bit 4 keeps the previous result
        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        issue(8'h55, 8'h22, 1'b0, 1'b0, 1'b0);
        idle(4);
        bus.abort = 1'b1;
        idle(1);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'h10);
        idle(W + 2);
        check("abort_sum_held", 32'(bus.sum), 32'h10);
        do_op(8'h33, 8'h44, 1'b0, 1'b0);

        // start wins over abort in IDLE
        bus.abort = 1'b1;
        issue(8'h90, 8'h90, 1'b0, 1'b0, 1'b1);
        bus.abort = 1'b0;
        idle(W + 1);

        // Asynchronous reset in the middle of RUN
        issue(8'h99, 8'h11, 1'b0, 1'b0, 1'b0);
        idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        do_op(8'h03, 8'h04, 1'b0, 1'b0);

        // Random operations with random idle gaps
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(W + 4);
        check("pending_results", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 cin  input  1  carry-in for add; ignored when sub=1.
REQ-007 a  input  WIDTH  operand A; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 abort  input  1  synchronous cancel of an operation in progress.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse when the result becomes valid.
REQ-012 sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-013 cout  output  1  final carry-out; for subtract, 1 = no borrow.
REQ-014 ovf  output  1  signed overflow, equal to carry into MSB XOR carry out of MSB.

Function
REQ-015 The block SHALL compute the result bit-serially, LSB first, through exactly one single-bit full-adder cell and a carry flip-flop.
REQ-016 States SHALL be IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> IDLE unconditionally after one cycle.
REQ-017 On the edge that accepts start in IDLE, the block SHALL perform all of the following:
- load a into operand register A;
- load b into operand register B, or ~b when sub=1;
- load the carry flop with cin, or with 1 when sub=1;
- clear the bit counter.
REQ-018 Each RUN edge SHALL perform all of the following:
- shift the cell sum bit into the MSB of the sum shift register;
- shift A and B right by one;
- update the carry flop;
- increment the counter.
REQ-019 The counter SHALL be $clog2(WIDTH) bits wide (minimum 1). RUN SHALL exit on the edge where counter = WIDTH-1; no wrap past that value is permitted.
REQ-020 done SHALL rise exactly WIDTH clock edges after the edge that sampled start. It SHALL be high only in DONE. Total throughput is WIDTH+2 cycles per operation, including the IDLE accept cycle.
REQ-021 The block SHALL capture the carry into the MSB on the last RUN edge and SHALL produce ovf from it.
REQ-022 In RUN and DONE, start SHALL be ignored: no queuing, no effect on the operation in progress.
REQ-023 start asserted in the DONE cycle SHALL be ignored. start asserted in the following IDLE cycle SHALL be accepted.
REQ-024 When abort=1 in RUN, the block SHALL return to IDLE on the next edge with done=0. sum, cout and ovf SHALL keep their previous valid values.
REQ-025 When abort=1 in IDLE or DONE, abort SHALL have no effect. When abort and start are both high in IDLE, start SHALL win.
REQ-026 sum, cout and ovf SHALL update only on the DONE transition and SHALL never expose partial results. The internal shift register SHALL be separate from the sum output register.

Reset
REQ-027 rst_n=0 SHALL immediately force all of the following, regardless of clk:
- state = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0, ovf = 0;
- counter, carry flop and operand registers = 0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation. After release, the first accepted start SHALL behave as a fresh operation.
REQ-029 Reset deassertion SHALL be the only reset-related event. No start SHALL be accepted on the edge coincident with deassertion.

Structure
REQ-030 A shared package serial_add_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 The bit cell SHALL be the team's existing FullAdder_gate, instantiated once as the sole sub-module. It SHALL not be reimplemented in the controller.
REQ-032 The controller SHALL contain no WIDTH-wide adder.

Verification (WIDTH=8)
REQ-033 Add: a=0x0F, b=0x01, cin=0, sub=0 -> done at edge 8 after start; sum=0x10, cout=0, ovf=0.
REQ-034 Carry and overflow: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-035 Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0 (borrow). Then a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-036 Busy protection: start pulsed at RUN bit 3 and in DONE -> exactly one done pulse; result matches the first operands only.
REQ-037 Abort at RUN bit 4 after a prior result of 0x10 -> state IDLE next edge, no done, sum stays 0x10. The next start completes normally.
REQ-038 rst_n low mid-RUN -> all outputs 0 asynchronously. After release, a=0x03, b=0x04 -> sum=0x07.
